// File: rtl/fir_pkg.sv
// Shared FIR filter/formatter definitions: default widths, output sample
// limits and the accumulator/sample types.
package fir_pkg;

  localparam int FIR_IN_WIDTH   = 64;
  localparam int FIR_OUT_WIDTH  = 16;
  localparam int FIR_FRAC_SHIFT = 31;

  typedef logic signed [FIR_IN_WIDTH-1:0]  acc_t;
  typedef logic signed [FIR_OUT_WIDTH-1:0] sample_t;

  localparam sample_t OUT_MAX = {1'b0, {(FIR_OUT_WIDTH-1){1'b1}}};
  localparam sample_t OUT_MIN = {1'b1, {(FIR_OUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fir_out_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; rdata_o holds the last popped word when empty.
module fir_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

  // Storage is not reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fir_out_formatter.sv
// FIR back end: warm-up discard, round-half-up rescale, saturation to the
// output width, output FIFO and saturation/drop statistics.
module fir_out_formatter
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_IN_WIDTH,
  parameter int OUT_WIDTH  = FIR_OUT_WIDTH,
  parameter int FRAC_SHIFT = FIR_FRAC_SHIFT,
  parameter int FIFO_DEPTH = 8,
  parameter int SKIP_COUNT = 102,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic [IN_WIDTH-1:0]             in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [CNT_WIDTH-1:0]            sat_count,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic                            overflow
);

  localparam int WW     = IN_WIDTH + 1;
  localparam int SKIP_W = (SKIP_COUNT > 0) ? $clog2(SKIP_COUNT + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(SKIP_COUNT);
  localparam logic signed [WW-1:0] HALF = {{(WW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [WW-1:0] SAT_MAX_W = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN_W = {{(WW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [SKIP_W-1:0]           skip_q, skip_d;
  logic                        s1_valid_q, s1_valid_d;
  logic signed [WW-1:0]        s1_data_q, s1_data_d;
  logic                        s2_valid_q, s2_valid_d;
  logic [OUT_WIDTH-1:0]        s2_data_q, s2_data_d;
  logic [CNT_WIDTH-1:0]        sat_cnt_q, sat_cnt_d;
  logic [CNT_WIDTH-1:0]        drop_cnt_q, drop_cnt_d;
  logic                        ovf_q, ovf_d;

  logic                        warm_done;
  logic signed [WW-1:0]        in_ext;
  logic                        sat_hi, sat_lo, sat_ev;
  logic                        fifo_full, fifo_empty, pop, drop;

  assign warm_done = (skip_q == SKIP_LIM);
  // One extra headroom bit so adding the rounding half never wraps.
  assign in_ext    = {in_data[IN_WIDTH-1], in_data};
  assign sat_hi    = s1_data_q > SAT_MAX_W;
  assign sat_lo    = s1_data_q < SAT_MIN_W;
  assign sat_ev    = s1_valid_q && (sat_hi || sat_lo);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = s2_valid_q && fifo_full && !pop;

  always_comb begin
    skip_d     = skip_q;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    s2_valid_d = s1_valid_q;
    s2_data_d  = s2_data_q;
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;

    if (in_valid) begin
      if (!warm_done) begin
        skip_d = skip_q + 1'b1;
      end else begin
        s1_valid_d = 1'b1;
        s1_data_d  = (in_ext + HALF) >>> FRAC_SHIFT;
      end
    end

    if (s1_valid_q) begin
      if (sat_hi)      s2_data_d = SAT_MAX_W[OUT_WIDTH-1:0];
      else if (sat_lo) s2_data_d = SAT_MIN_W[OUT_WIDTH-1:0];
      else             s2_data_d = s1_data_q[OUT_WIDTH-1:0];
    end

    if (sat_ev && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else if (clear) begin
      skip_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      skip_q     <= skip_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  fir_out_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr_i   (clear),
    .push_i  (s2_valid_q),
    .pop_i   (out_ready),
    .wdata_i (s2_data_q),
    .rdata_o (out_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sat_count  = sat_cnt_q;
  assign drop_count = drop_cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/fir_out_formatter.md
Name: fir_out_formatter

Overview:
Back-end companion to the pipelined FIR filter. Consumes the filter's wide accumulator output and applies fixed-point rescale with round-half-up, then saturates to the output sample width. Buffers results in a small FIFO and delivers them on a valid/ready stream to the downstream sink (DAC interface or capture logic). Also discards the filter's warm-up samples and reports saturation and drop statistics.

Parameters:
IN_WIDTH, 64, width of signed filter accumulator input
OUT_WIDTH, 16, width of signed output sample
FRAC_SHIFT, 31, right-shift applied for rescale (taps are Q1.31); must be >=1 and < IN_WIDTH
FIFO_DEPTH, 8, output FIFO entries; power of two, >=2
SKIP_COUNT, 102, number of leading valid inputs discarded after reset/clear (filter fill); 0 disables
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear: flushes pipeline/FIFO, zeroes counters, re-arms warm-up skip
in_valid  in  1  in_data carries a filter output this cycle
in_data  in  IN_WIDTH  signed accumulator value
out_valid  out  1  out_data holds a sample
out_ready  in  1  sink accepts sample this cycle
out_data  out  OUT_WIDTH  signed rounded/saturated sample
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
sat_count  out  CNT_WIDTH  samples that saturated (saturating counter)
drop_count  out  CNT_WIDTH  samples lost to full FIFO (saturating counter)
overflow  out  1  sticky: set on first drop, cleared only by reset/clear

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_data=0, fifo_level=0, sat_count=0, drop_count=0, overflow=0, pipeline valids=0, skip counter=0. clear has identical effect, synchronously; clear wins over any same-cycle input or pop.
- Warm-up: while skip counter < SKIP_COUNT, each in_valid increments the counter and the sample is discarded (no stage, no stats). Afterwards, samples enter stage 1.
- Stage 1 (registered): r = (in_data + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed in IN_WIDTH+1 bits so the add cannot wrap; arithmetic shift; round-half-up (+0.5 -> 1, -0.5 -> 0, -1.5 -> -1).
- Stage 2 (registered): if r > 2^(OUT_WIDTH-1)-1 -> max; if r < -2^(OUT_WIDTH-1) -> min; else truncate. Saturation increments sat_count (holds at all-ones).
- FIFO write on stage-2 valid. Accepted if level < FIFO_DEPTH, or if level == FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the sample is dropped, drop_count increments (saturating), overflow sets. Drops do not stall upstream; the filter cannot be back-pressured.
- Latency: in_valid high in cycle 0 (post-warm-up, FIFO empty) -> out_valid high, with that sample on out_data, in cycle 3.
- Output: show-ahead FIFO. out_valid = level != 0. Pop when out_valid && out_ready. out_data is stable while out_valid && !out_ready. Order preserved. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: level unchanged. Push into empty FIFO plus out_ready: no same-cycle bypass; the sample appears the next cycle.
- out_data holds the last popped value when empty (0 after reset).
- Reset mid-stream: all in-flight and buffered samples are lost; the warm-up skip re-arms.

Decomposition:
- Shared package fir_pkg: IN_WIDTH/OUT_WIDTH/FRAC_SHIFT defaults, OUT_MAX/OUT_MIN constants, sample_t typedefs (acc_t, sample_t). Filter and formatter both import it.
- One sub-module: fir_out_fifo (parameterised synchronous FIFO: push, pop, data, level, full/empty). Rounding, saturation, skip and statistics stay in the top.

Test Plan:
- Reset/warm-up: SKIP_COUNT=102, drive 102 valids of 5<<31 then one of 7<<31 -> no out_valid for the first 102; single output 7 in cycle 3 after the 103rd; all counters 0.
- Rounding (SKIP_COUNT=0): inputs 2^31, 2^30, -(2^30), -3*2^30, -(2^31) -> outputs 1, 1, 0, -1, -1 in order; sat_count=0.
- Saturation: inputs 40000<<31, -40000<<31, 32767<<31 -> 32767, -32768, 32767; sat_count=2.
- Back-pressure/overflow: out_ready=0, 12 consecutive valids of 1..12 (<<31) -> fifo_level=8, drop_count=4, overflow=1. Then out_ready=1 -> pops 1..8 in order, fifo_level returns to 0.
- Full with simultaneous pop: fill to 8, then push 9<<31 while popping -> accepted, level stays 8, drop_count unchanged. Stall out_ready mid-stream -> out_data stable.
- Async reset mid-operation: FIFO holding 5 entries and sat_count=3, pulse reset_n low between clock edges -> outputs 0 immediately. Skip re-armed: the next SKIP_COUNT inputs are discarded. Repeat the scenario with clear to get the same result synchronously.
